// File: rtl/mpmc10_cmd_fsm.sv
// mpmc10 per-channel command sequencer: takes one arbiter request and drives the MIG app_* handshakes.
// Optional macro MPMC10_BURST_EN honours req_len (multi-beat bursts); without it every transaction is one beat.
module mpmc10_cmd_fsm #(
    parameter int unsigned TO_BIT    = 9,
    parameter int unsigned MAX_BEATS = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         mem_ui_rdy,
    input  logic                         req_valid,
    input  logic                         req_we,
    input  logic [$clog2(MAX_BEATS)-1:0] req_len,
    output logic                         req_ack,
    output logic                         app_en,
    output logic [2:0]                   app_cmd,
    input  logic                         app_rdy,
    output logic                         app_wdf_wren,
    output logic                         app_wdf_end,
    input  logic                         app_wdf_rdy,
    input  logic                         app_rd_data_valid,
    input  logic                         app_rd_data_end,
    input  logic [15:0]                  to_cnt,
    output logic [3:0]                   state,
    output logic [3:0]                   prev_state,
    output logic                         done,
    output logic                         timeout_err
);
    localparam int unsigned CW = $clog2(MAX_BEATS);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        PRESET     = 4'd1,
        WRITE_DATA = 4'd2,
        SEND_CMD   = 4'd3,
        READ_DATA  = 4'd4,
        DONE       = 4'd5
    } state_t;

    state_t cur;
    logic   we_q;
    logic   last_beat;
    logic   abort;
    logic   accept;
    logic   unused_ok;

    assign abort  = (cur != IDLE) && to_cnt[TO_BIT];
    assign accept = (cur == IDLE) && mem_ui_rdy && req_valid;

    // Read termination counts beats; app_rd_data_end is informational only.
    assign unused_ok = ^{app_rd_data_end, to_cnt, req_len};

`ifdef MPMC10_BURST_EN
    logic [CW-1:0] len_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q <= '0;
            cnt   <= '0;
        end else if (!abort) begin
            case (cur)
                IDLE:       if (accept) len_q <= req_len;
                PRESET:     cnt <= len_q;
                WRITE_DATA: if (app_wdf_rdy && cnt != '0) cnt <= cnt - 1'b1;
                SEND_CMD:   if (app_rdy && !we_q) cnt <= len_q;
                READ_DATA:  if (app_rd_data_valid && cnt != '0) cnt <= cnt - 1'b1;
                default:    ;
            endcase
        end
    end

    assign last_beat = (cnt == '0);
`else
    assign last_beat = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur         <= IDLE;
            prev_state  <= 4'd0;
            we_q        <= 1'b0;
            req_ack     <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            prev_state  <= cur;
            req_ack     <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            // A timeout overrides any handshake completing on the same edge.
            if (abort) begin
                cur         <= IDLE;
                timeout_err <= 1'b1;
            end else begin
                case (cur)
                    IDLE: begin
                        if (accept) begin
                            we_q    <= req_we;
                            req_ack <= 1'b1;
                            cur     <= PRESET;
                        end
                    end
                    PRESET:     cur <= we_q ? WRITE_DATA : SEND_CMD;
                    WRITE_DATA: if (app_wdf_rdy && last_beat) cur <= SEND_CMD;
                    SEND_CMD: begin
                        if (app_rdy) begin
                            if (we_q) begin
                                cur  <= DONE;
                                done <= 1'b1;
                            end else begin
                                cur <= READ_DATA;
                            end
                        end
                    end
                    READ_DATA: begin
                        if (app_rd_data_valid && last_beat) begin
                            cur  <= DONE;
                            done <= 1'b1;
                        end
                    end
                    DONE:    cur <= IDLE;
                    default: cur <= IDLE;
                endcase
            end
        end
    end

    assign state        = cur;
    assign app_en       = (cur == SEND_CMD);
    assign app_cmd      = ((cur == SEND_CMD) && !we_q) ? 3'b001 : 3'b000;
    assign app_wdf_wren = (cur == WRITE_DATA);
    assign app_wdf_end  = (cur == WRITE_DATA) && last_beat;

endmodule

// File: tb/tb_mpmc10_cmd_fsm.sv
// Directed bench for mpmc10_cmd_fsm: transaction-level reference model checked every cycle plus literal checks.
module tb_mpmc10_cmd_fsm;
    localparam int TO_BIT = 9;
`ifdef MPMC10_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_ui_rdy, req_valid, req_we;
    logic [2:0]  req_len;
    logic        req_ack, app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy;
    logic [2:0]  app_cmd;
    logic        app_rd_data_valid, app_rd_data_end;
    logic [15:0] to_cnt;
    logic [3:0]  state, prev_state;
    logic        done, timeout_err;

    int checks = 0;
    int errors = 0;

    mpmc10_cmd_fsm #(.TO_BIT(TO_BIT), .MAX_BEATS(8)) dut (
        .clk(clk), .rst_n(rst_n), .mem_ui_rdy(mem_ui_rdy), .req_valid(req_valid),
        .req_we(req_we), .req_len(req_len), .req_ack(req_ack), .app_en(app_en),
        .app_cmd(app_cmd), .app_rdy(app_rdy), .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data_valid(app_rd_data_valid), .app_rd_data_end(app_rd_data_end),
        .to_cnt(to_cnt), .state(state), .prev_state(prev_state), .done(done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase code plus number of beats still owed by the current transaction.
    int m_state = 0, m_prev = 0, m_left = 0, m_len = 0;
    bit m_we = 0, m_ack = 0, m_done = 0, m_to = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_prev = 0; m_left = 0; m_len = 0;
            m_we = 0; m_ack = 0; m_done = 0; m_to = 0;
        end else begin
            m_prev = m_state;
            m_ack = 0; m_done = 0; m_to = 0;
            if (m_state != 0 && to_cnt[TO_BIT]) begin
                m_state = 0;
                m_to = 1;
            end else begin
                case (m_state)
                    0: if (mem_ui_rdy && req_valid) begin
                        m_we = req_we;
                        m_len = BURST ? int'(req_len) : 0;
                        m_ack = 1;
                        m_state = 1;
                    end
                    1: begin
                        m_left = m_len + 1;
                        m_state = m_we ? 2 : 3;
                    end
                    2: if (app_wdf_rdy) begin
                        m_left = m_left - 1;
                        if (m_left == 0) m_state = 3;
                    end
                    3: if (app_rdy) begin
                        if (m_we) begin
                            m_state = 5;
                            m_done = 1;
                        end else begin
                            m_left = m_len + 1;
                            m_state = 4;
                        end
                    end
                    4: if (app_rd_data_valid) begin
                        m_left = m_left - 1;
                        if (m_left == 0) begin
                            m_state = 5;
                            m_done = 1;
                        end
                    end
                    default: m_state = 0;
                endcase
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("state", state, m_state);
        chk("prev_state", prev_state, m_prev);
        chk("req_ack", req_ack, m_ack);
        chk("done", done, m_done);
        chk("timeout_err", timeout_err, m_to);
        chk("app_en", app_en, m_state == 3);
        chk("app_cmd", app_cmd, (m_state == 3 && !m_we) ? 1 : 0);
        chk("app_wdf_wren", app_wdf_wren, m_state == 2);
        chk("app_wdf_end", app_wdf_end, m_state == 2 && m_left == 1);
    end

    // Transaction recorder for literal per-scenario expectations.
    bit         rec_on = 0;
    logic [3:0] seq[$];
    int n_beats, n_ends, end_idx, n_done, n_to, n_ack, n_cmd_rd, n_cmd_wr;

    task automatic rec_start();
        seq.delete();
        seq.push_back(state);
        n_beats = 0; n_ends = 0; end_idx = 0; n_done = 0;
        n_to = 0; n_ack = 0; n_cmd_rd = 0; n_cmd_wr = 0;
        rec_on = 1;
    endtask

    function automatic logic [31:0] seq_packed();
        logic [31:0] v = '0;
        foreach (seq[i]) v = (v << 4) | 32'(seq[i]);
        return v;
    endfunction

    always @(posedge clk) begin
        if (rec_on && app_wdf_wren && app_wdf_rdy) begin
            n_beats++;
            if (app_wdf_end) begin
                n_ends++;
                end_idx = n_beats;
            end
        end
        #1;
        if (rec_on) begin
            if (seq[$] != state) seq.push_back(state);
            if (done) n_done++;
            if (timeout_err) n_to++;
            if (req_ack) n_ack++;
            if (app_en && app_cmd == 3'b001) n_cmd_rd++;
            if (app_en && app_cmd == 3'b000) n_cmd_wr++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    localparam logic [1:0] WPAT [6] = '{2'd1, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1};

    initial begin
        rst_n = 0; mem_ui_rdy = 0; req_valid = 0; req_we = 0; req_len = '0;
        app_rdy = 0; app_wdf_rdy = 0; app_rd_data_valid = 0; app_rd_data_end = 0;
        to_cnt = '0;

        repeat (3) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_prev", prev_state, 0);
        chk("rst_pulses", {req_ack, done, timeout_err}, 0);
        chk("rst_app", {app_en, app_wdf_wren, app_wdf_end, app_cmd}, 0);
        rst_n = 1;

        // Reset asserted while in WRITE_DATA
        @(negedge clk); mem_ui_rdy = 1; req_valid = 1; req_we = 1; req_len = 3'd3;
        @(negedge clk); req_valid = 0;
        @(negedge clk);
        chk("wd_state", state, 2);
        chk("wd_wren", app_wdf_wren, 1);
        #2 rst_n = 0;
        #1;
        chk("async_state", state, 0);
        chk("async_prev", prev_state, 0);
        chk("async_outs", {req_ack, done, timeout_err, app_wdf_wren}, 0);
        @(negedge clk); rst_n = 1; req_valid = 1; req_we = 0; req_len = '0;
        @(posedge clk); #2;
        chk("post_rst_ack", req_ack, 1);
        chk("post_rst_state", state, 1);
        @(negedge clk); req_valid = 0;

        // Stall in SEND_CMD, then timeout
        repeat (4) @(negedge clk);
        chk("stall_state", state, 3);
        to_cnt = 16'h0200;
        @(posedge clk); #2;
        chk("to_state", state, 0);
        chk("to_err", timeout_err, 1);
        chk("to_done", done, 0);
        @(negedge clk); to_cnt = '0;
        @(posedge clk); #2;
        chk("to_err_pulse", timeout_err, 0);

        // Single read, data beat three cycles after READ_DATA entry
        @(negedge clk); rec_start(); req_valid = 1; req_we = 0; req_len = '0; app_rdy = 1;
        @(negedge clk); req_valid = 0;
        @(negedge clk);
        @(negedge clk); app_rdy = 0;
        repeat (2) @(negedge clk);
        app_rd_data_valid = 1; app_rd_data_end = 1;
        @(negedge clk); app_rd_data_valid = 0; app_rd_data_end = 0;
        repeat (2) @(negedge clk);
        rec_on = 0;
        chk("rd_seq_len", seq.size(), 6);
        chk("rd_seq", seq_packed(), 32'h013450);
        chk("rd_done_cnt", n_done, 1);
        chk("rd_cmd_cycles", n_cmd_rd, 1);

        // Write len=3 with app_wdf_rdy toggling 1,0,1,1,0,1
        @(negedge clk); rec_start(); req_valid = 1; req_we = 1; req_len = 3'd3;
        @(negedge clk); req_valid = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); app_wdf_rdy = WPAT[i][0];
        end
        @(negedge clk); app_wdf_rdy = 0;
        @(negedge clk); app_rdy = 1;
        @(negedge clk); app_rdy = 0;
        repeat (2) @(negedge clk);
        rec_on = 0;
        chk("wr_beats", n_beats, BURST ? 4 : 1);
        chk("wr_end_cnt", n_ends, 1);
        chk("wr_end_idx", end_idx, BURST ? 4 : 1);
        chk("wr_cmd_cycles", n_cmd_wr, BURST ? 2 : 7);
        chk("wr_done_cnt", n_done, 1);
        chk("wr_seq", seq_packed(), 32'h012350);

        // Timeout coincident with app_rdy on a read
        @(negedge clk); rec_start(); req_valid = 1; req_we = 0; req_len = '0;
        @(negedge clk); req_valid = 0;
        @(negedge clk); app_rdy = 1; to_cnt = 16'h0200;
        @(posedge clk); #2;
        chk("co_state", state, 0);
        chk("co_err", timeout_err, 1);
        @(negedge clk); app_rdy = 0; to_cnt = '0;
        repeat (2) @(negedge clk);
        rec_on = 0;
        chk("co_seq", seq_packed(), 32'h0130);
        chk("co_done_cnt", n_done, 0);
        chk("co_to_cnt", n_to, 1);

        // Requests held off while calibration is incomplete
        @(negedge clk); rec_start(); mem_ui_rdy = 0; req_valid = 1; req_we = 1; req_len = '0;
        repeat (20) @(negedge clk);
        rec_on = 0;
        chk("cal_ack_cnt", n_ack, 0);
        chk("cal_seq", seq_packed(), 32'h0);
        mem_ui_rdy = 1;
        @(posedge clk); #2;
        chk("cal_ack", req_ack, 1);
        chk("cal_state", state, 1);
        @(negedge clk); req_valid = 0; app_wdf_rdy = 1; app_rdy = 1;
        repeat (6) @(negedge clk);
        app_wdf_rdy = 0; app_rdy = 0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
